// File: rtl/axil_cfg_bridge_if.sv
// AXI4-Lite channel bundle between the host driver (master) and the config bridge (slave).
interface axil_cfg_bridge_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [2:0]              awprot;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [2:0]              arprot;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, arprot, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, arprot, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cfg_bridge.sv
// Purpose: AXI4-Lite slave serialising single-beat reads/writes onto one config register port.
// Latency: cfg strobe 1 cycle after request held; B 1 cycle after strobe; R 1 cycle after cfg_rd_valid.
// Backpressure: one-entry AW/W/AR buffers freed only on B/R handshake; B/R held while ready low.
module axil_cfg_bridge #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    axil_cfg_bridge_if.slave        axi,
    output logic [ADDR_WIDTH-1:0]   cfg_addr,
    output logic                    cfg_wr_en,
    output logic [DATA_WIDTH-1:0]   cfg_wdata,
    output logic [DATA_WIDTH/8-1:0] cfg_wstrb,
    output logic                    cfg_rd_en,
    input  logic [DATA_WIDTH-1:0]   cfg_rdata,
    input  logic                    cfg_rd_valid
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST    = CW'(RD_TIMEOUT - 1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SW-1:0]         strb;
    } wbuf_t;

    // Request holding buffers
    logic                  aw_vld;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_vld;
    wbuf_t                 w_dat;
    logic                  ar_vld;
    logic [ADDR_WIDTH-1:0] ar_addr;

    // FSM and registered outputs
    state_t                state,        state_nxt;
    logic                  last_rd,      last_rd_nxt;
    logic [CW-1:0]         cnt,          cnt_nxt;
    logic [ADDR_WIDTH-1:0]                cfg_addr_nxt;
    logic                                 cfg_wr_en_nxt;
    logic [DATA_WIDTH-1:0]                cfg_wdata_nxt;
    logic [SW-1:0]                        cfg_wstrb_nxt;
    logic                                 cfg_rd_en_nxt;
    logic                  bvalid_q,     bvalid_nxt;
    logic [1:0]            bresp_q,      bresp_nxt;
    logic                  rvalid_q,     rvalid_nxt;
    logic [1:0]            rresp_q,      rresp_nxt;
    logic [DATA_WIDTH-1:0] rdata_q,      rdata_nxt;

    logic wr_cand;
    logic grant_wr;
    logic grant_rd;
    logic wr_done;
    logic rd_done;

    logic unused_prot;
    assign unused_prot = ^{axi.awprot, axi.arprot};

    assign axi.awready = ~aw_vld;
    assign axi.wready  = ~w_vld;
    assign axi.arready = ~ar_vld;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_vld  <= 1'b0;
            aw_addr <= '0;
            w_vld   <= 1'b0;
            w_dat   <= '0;
            ar_vld  <= 1'b0;
            ar_addr <= '0;
        end else begin
            if (wr_done) begin
                aw_vld <= 1'b0;
                w_vld  <= 1'b0;
            end else begin
                if (axi.awvalid && !aw_vld) begin
                    aw_vld  <= 1'b1;
                    aw_addr <= axi.awaddr;
                end
                if (axi.wvalid && !w_vld) begin
                    w_vld      <= 1'b1;
                    w_dat.data <= axi.wdata;
                    w_dat.strb <= axi.wstrb;
                end
            end
            if (rd_done) begin
                ar_vld <= 1'b0;
            end else if (axi.arvalid && !ar_vld) begin
                ar_vld  <= 1'b1;
                ar_addr <= axi.araddr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_rd   <= 1'b1;
            cnt       <= '0;
            cfg_addr  <= '0;
            cfg_wr_en <= 1'b0;
            cfg_wdata <= '0;
            cfg_wstrb <= '0;
            cfg_rd_en <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            last_rd   <= last_rd_nxt;
            cnt       <= cnt_nxt;
            cfg_addr  <= cfg_addr_nxt;
            cfg_wr_en <= cfg_wr_en_nxt;
            cfg_wdata <= cfg_wdata_nxt;
            cfg_wstrb <= cfg_wstrb_nxt;
            cfg_rd_en <= cfg_rd_en_nxt;
            bvalid_q  <= bvalid_nxt;
            bresp_q   <= bresp_nxt;
            rvalid_q  <= rvalid_nxt;
            rresp_q   <= rresp_nxt;
            rdata_q   <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        last_rd_nxt   = last_rd;
        cnt_nxt       = cnt;
        cfg_addr_nxt  = cfg_addr;
        cfg_wr_en_nxt = 1'b0;
        cfg_wdata_nxt = cfg_wdata;
        cfg_wstrb_nxt = cfg_wstrb;
        cfg_rd_en_nxt = 1'b0;
        bvalid_nxt    = bvalid_q;
        bresp_nxt     = bresp_q;
        rvalid_nxt    = rvalid_q;
        rresp_nxt     = rresp_q;
        rdata_nxt     = rdata_q;
        wr_done       = 1'b0;
        rd_done       = 1'b0;

        // Only a genuine tie flips the alternation bit; an uncontested grant leaves it alone.
        wr_cand  = aw_vld && w_vld;
        grant_wr = wr_cand && (!ar_vld || last_rd);
        grant_rd = ar_vld && !grant_wr;

        case (state)
            IDLE: begin
                if (wr_cand && ar_vld) begin
                    last_rd_nxt = grant_rd;
                end
                if (grant_wr) begin
                    if (aw_addr[1:0] == 2'b00) begin
                        state_nxt     = WR_ISSUE;
                        cfg_wr_en_nxt = 1'b1;
                        cfg_addr_nxt  = aw_addr;
                        cfg_wdata_nxt = w_dat.data;
                        cfg_wstrb_nxt = w_dat.strb;
                    end else begin
                        state_nxt  = WR_RESP;
                        bvalid_nxt = 1'b1;
                        bresp_nxt  = RESP_SLVERR;
                    end
                end else if (grant_rd) begin
                    if (ar_addr[1:0] == 2'b00) begin
                        state_nxt     = RD_ISSUE;
                        cfg_rd_en_nxt = 1'b1;
                        cfg_addr_nxt  = ar_addr;
                    end else begin
                        state_nxt  = RD_RESP;
                        rvalid_nxt = 1'b1;
                        rresp_nxt  = RESP_SLVERR;
                        rdata_nxt  = '0;
                    end
                end
            end
            WR_ISSUE: begin
                state_nxt  = WR_RESP;
                bvalid_nxt = 1'b1;
                bresp_nxt  = RESP_OKAY;
            end
            WR_RESP: begin
                if (axi.bready) begin
                    state_nxt  = IDLE;
                    bvalid_nxt = 1'b0;
                    wr_done    = 1'b1;
                end
            end
            RD_ISSUE: begin
                state_nxt = RD_WAIT;
                cnt_nxt   = '0;
            end
            RD_WAIT: begin
                // Data arriving on the last allowed cycle still beats the timeout.
                if (cfg_rd_valid) begin
                    state_nxt  = RD_RESP;
                    rvalid_nxt = 1'b1;
                    rresp_nxt  = RESP_OKAY;
                    rdata_nxt  = cfg_rdata;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = RD_RESP;
                    rvalid_nxt = 1'b1;
                    rresp_nxt  = RESP_SLVERR;
                    rdata_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RD_RESP: begin
                if (axi.rready) begin
                    state_nxt  = IDLE;
                    rvalid_nxt = 1'b0;
                    rd_done    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_axil_cfg_bridge.sv
// Directed bench for axil_cfg_bridge: writes, reads, timeout, misalignment, arbitration, reset.
module tb_axil_cfg_bridge;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   cfg_addr;
    logic            cfg_wr_en;
    logic [DW-1:0]   cfg_wdata;
    logic [DW/8-1:0] cfg_wstrb;
    logic            cfg_rd_en;
    logic [DW-1:0]   cfg_rdata;
    logic            cfg_rd_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int wr_cyc = 0;
    int rd_cyc = 0;
    int w0, r0, early;

    axil_cfg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

    axil_cfg_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RD_TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .axi          (axi),
        .cfg_addr     (cfg_addr),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wdata    (cfg_wdata),
        .cfg_wstrb    (cfg_wstrb),
        .cfg_rd_en    (cfg_rd_en),
        .cfg_rdata    (cfg_rdata),
        .cfg_rd_valid (cfg_rd_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc++;
        if (cfg_wr_en) begin
            wr_cnt++;
            wr_cyc = ncyc;
        end
        if (cfg_rd_en) begin
            rd_cnt++;
            rd_cyc = ncyc;
        end
        if (cfg_wr_en && cfg_rd_en) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write and read presented in the same cycle; a small responder answers the read.
    task automatic tie_run(input string tag, input logic [AW-1:0] waddr, input logic [AW-1:0] raddr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd, input bit wr_first);
        bit done_w = 1'b0;
        bit done_r = 1'b0;
        bit pend   = 1'b0;
        int ws, rs;
        ws = wr_cnt;
        rs = rd_cnt;
        axi.awaddr = waddr; axi.awvalid = 1'b1;
        axi.wdata = wd; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        axi.araddr = raddr; axi.arvalid = 1'b1;
        axi.bready = 1'b1; axi.rready = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        for (int i = 0; i < 30 && !(done_w && done_r); i++) begin
            tick();
            cfg_rd_valid = pend;
            cfg_rdata = rd;
            pend = cfg_rd_en;
            if (cfg_wr_en) check({tag, "_cfg_waddr"}, cfg_addr, waddr);
            if (cfg_rd_en) check({tag, "_cfg_raddr"}, cfg_addr, raddr);
            if (axi.bvalid && !done_w) begin
                done_w = 1'b1;
                check({tag, "_bresp"}, axi.bresp, 2'b00);
            end
            if (axi.rvalid && !done_r) begin
                done_r = 1'b1;
                check({tag, "_rdata"}, axi.rdata, rd);
            end
        end
        cfg_rd_valid = 1'b0;
        tick();
        check({tag, "_b_seen"}, done_w, 1'b1);
        check({tag, "_r_seen"}, done_r, 1'b1);
        check({tag, "_wr_pulses"}, wr_cnt - ws, 1);
        check({tag, "_rd_pulses"}, rd_cnt - rs, 1);
        check({tag, "_wr_first"}, (wr_cyc < rd_cyc), wr_first);
    endtask

    initial begin
        reset = 1'b1;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.awprot = 3'b000;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arvalid = 1'b0; axi.arprot = 3'b000; axi.rready = 1'b0;
        cfg_rdata = '0; cfg_rd_valid = 1'b0;
        repeat (3) tick();

        check("rst_awready", axi.awready, 1'b1);
        check("rst_wready", axi.wready, 1'b1);
        check("rst_arready", axi.arready, 1'b1);
        check("rst_bvalid", axi.bvalid, 1'b0);
        check("rst_rvalid", axi.rvalid, 1'b0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_cfg_wr_en", cfg_wr_en, 1'b0);
        check("rst_cfg_rd_en", cfg_rd_en, 1'b0);
        check("rst_cfg_addr", cfg_addr, 13'h0);
        reset = 1'b0;

        // Aligned write, AW and W together
        axi.awaddr = 13'h010; axi.awvalid = 1'b1;
        axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        check("w1_awready_c0", axi.awready, 1'b0);
        check("w1_wr_en_c0", cfg_wr_en, 1'b0);
        tick();
        check("w1_wr_en_c1", cfg_wr_en, 1'b1);
        check("w1_addr", cfg_addr, 13'h010);
        check("w1_wdata", cfg_wdata, 32'hDEADBEEF);
        check("w1_wstrb", cfg_wstrb, 4'hF);
        check("w1_bvalid_c1", axi.bvalid, 1'b0);
        tick();
        check("w1_wr_en_c2", cfg_wr_en, 1'b0);
        check("w1_bvalid_c2", axi.bvalid, 1'b1);
        check("w1_bresp", axi.bresp, 2'b00);
        tick();
        check("w1_bvalid_c3", axi.bvalid, 1'b0);
        check("w1_awready_c3", axi.awready, 1'b1);
        check("w1_wready_c3", axi.wready, 1'b1);

        // W leads AW by 3 cycles, B backpressured
        w0 = wr_cnt;
        axi.wdata = 32'hCAFEF00D; axi.wstrb = 4'h3; axi.wvalid = 1'b1; axi.bready = 1'b0;
        tick();
        axi.wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("w2_wready_wait", axi.wready, 1'b0);
            check("w2_no_early_wr", cfg_wr_en, 1'b0);
            tick();
        end
        axi.awaddr = 13'h044; axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        tick();
        check("w2_wr_en", cfg_wr_en, 1'b1);
        check("w2_addr", cfg_addr, 13'h044);
        check("w2_wdata", cfg_wdata, 32'hCAFEF00D);
        check("w2_wstrb", cfg_wstrb, 4'h3);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("w2_bvalid_hold", axi.bvalid, 1'b1);
            check("w2_wready_hold", axi.wready, 1'b0);
            check("w2_wr_en_quiet", cfg_wr_en, 1'b0);
            if (i == 4) axi.bready = 1'b1;
            tick();
        end
        check("w2_bvalid_done", axi.bvalid, 1'b0);
        check("w2_wready_back", axi.wready, 1'b1);
        check("w2_awready_back", axi.awready, 1'b1);
        check("w2_single_strobe", wr_cnt - w0, 1);

        // Aligned read, data 4 cycles after cfg_rd_en, stray valid during issue
        r0 = rd_cnt;
        axi.araddr = 13'h020; axi.arvalid = 1'b1; axi.rready = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        check("r1_arready_c0", axi.arready, 1'b0);
        check("r1_rd_en_c0", cfg_rd_en, 1'b0);
        tick();
        check("r1_rd_en_c1", cfg_rd_en, 1'b1);
        check("r1_addr", cfg_addr, 13'h020);
        check("r1_no_wr", cfg_wr_en, 1'b0);
        cfg_rd_valid = 1'b1; cfg_rdata = 32'hBADBAD00;
        tick();
        cfg_rd_valid = 1'b0;
        check("r1_rd_en_c2", cfg_rd_en, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            check("r1_rvalid_wait", axi.rvalid, 1'b0);
            tick();
        end
        check("r1_rvalid_c5", axi.rvalid, 1'b0);
        cfg_rd_valid = 1'b1; cfg_rdata = 32'h12345678;
        tick();
        cfg_rd_valid = 1'b0;
        check("r1_rvalid_c6", axi.rvalid, 1'b1);
        check("r1_rdata", axi.rdata, 32'h12345678);
        check("r1_rresp", axi.rresp, 2'b00);
        tick();
        check("r1_rvalid_done", axi.rvalid, 1'b0);
        check("r1_arready_back", axi.arready, 1'b1);
        check("r1_single_strobe", rd_cnt - r0, 1);

        // Read timeout, RD_TIMEOUT=8 -> R in cycle 10
        axi.araddr = 13'h030; axi.arvalid = 1'b1; axi.rready = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        early = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (axi.rvalid) early++;
        end
        check("to_no_early_rvalid", early, 0);
        tick();
        check("to_rvalid_c10", axi.rvalid, 1'b1);
        check("to_rdata", axi.rdata, 32'h0);
        check("to_rresp", axi.rresp, 2'b10);
        tick();
        check("to_rvalid_done", axi.rvalid, 1'b0);

        tie_run("tie1", 13'h050, 13'h060, 32'h11111111, 32'hA5A5A5A5, 1'b1);
        tie_run("tie2", 13'h054, 13'h064, 32'h22222222, 32'h5A5A5A5A, 1'b0);

        // Misaligned write: SLVERR in cycle 1, no strobe
        w0 = wr_cnt;
        axi.awaddr = 13'h013; axi.awvalid = 1'b1;
        axi.wdata = 32'h00000055; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        tick();
        check("mw_bvalid_c1", axi.bvalid, 1'b1);
        check("mw_bresp", axi.bresp, 2'b10);
        tick();
        check("mw_bvalid_done", axi.bvalid, 1'b0);
        check("mw_no_strobe", wr_cnt - w0, 0);

        // Aligned write with zero strobes still issues
        axi.awaddr = 13'h014; axi.awvalid = 1'b1;
        axi.wdata = 32'h0BADF00D; axi.wstrb = 4'h0; axi.wvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        tick();
        check("z_wr_en", cfg_wr_en, 1'b1);
        check("z_wstrb", cfg_wstrb, 4'h0);
        tick();
        check("z_bresp", axi.bresp, 2'b00);
        tick();

        // Misaligned read after a nonzero rdata: SLVERR, data zeroed
        r0 = rd_cnt;
        axi.araddr = 13'h022; axi.arvalid = 1'b1; axi.rready = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        tick();
        check("mr_rvalid_c1", axi.rvalid, 1'b1);
        check("mr_rresp", axi.rresp, 2'b10);
        check("mr_rdata", axi.rdata, 32'h0);
        tick();
        check("mr_rvalid_done", axi.rvalid, 1'b0);
        check("mr_no_strobe", rd_cnt - r0, 0);

        // Reset while waiting for read data
        axi.araddr = 13'h070; axi.arvalid = 1'b1; axi.rready = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1; cfg_rd_valid = 1'b1; cfg_rdata = 32'h77777777;
        tick();
        check("rr_rvalid", axi.rvalid, 1'b0);
        check("rr_arready", axi.arready, 1'b1);
        check("rr_rd_en", cfg_rd_en, 1'b0);
        check("rr_wr_en", cfg_wr_en, 1'b0);
        reset = 1'b0;
        tick();
        cfg_rd_valid = 1'b0;
        check("rr_rvalid_after", axi.rvalid, 1'b0);
        tick();
        check("rr_rvalid_late", axi.rvalid, 1'b0);
        check("rr_arready_late", axi.arready, 1'b1);

        check("never_both_strobes", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axil_cfg_bridge.md
# axil_cfg_bridge

AXI4-Lite slave that terminates the test-bench/host AXI4-Lite driver and converts each transaction into a single-beat access on a simple configuration register bus. It sits directly downstream of the AXI4-Lite driver and upstream of the CGRA/global-controller configuration registers. It serialises reads and writes onto one shared config port, generates AXI responses, flags misaligned addresses, and times out unresponsive reads.

## Interface
- ADDR_WIDTH, 13, AXI and config address width
- DATA_WIDTH, 32, data width (multiple of 8)
- RD_TIMEOUT, 255, max cycles waiting for cfg_rd_valid before SLVERR (≥1)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- awaddr/awvalid/awready/awprot  in/in/out/in  ADDR_WIDTH/1/1/3  AW channel (awprot ignored)
- wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel
- bresp/bvalid/bready  out/out/in  2/1/1  B channel
- araddr/arvalid/arready/arprot  in/in/out/in  ADDR_WIDTH/1/1/3  AR channel (arprot ignored)
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  R channel
- cfg_addr  output  ADDR_WIDTH  config word address (byte address as received)
- cfg_wr_en  output  1  one-cycle write strobe
- cfg_wdata / cfg_wstrb  output  DATA_WIDTH / DATA_WIDTH/8  write data / byte enables
- cfg_rd_en  output  1  one-cycle read strobe
- cfg_rdata  input  DATA_WIDTH  read data, valid with cfg_rd_valid
- cfg_rd_valid  input  1  read-data-valid pulse from register file

## Operation
- One-entry holding buffers for AW, W, AR. awready = AW buffer empty; wready = W buffer empty; arready = AR buffer empty. AW and W accepted independently, in either order or same cycle.
- Buffers freed only on their response handshake (B for AW+W, R for AR); one outstanding write and one outstanding read max.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE: write candidate = AW and W both held; read candidate = AR held. Both candidates -> grant opposite of last grant; last grant resets to "read" so write wins first tie.
- Write, addr[1:0]==0: -> WR_ISSUE (cfg_wr_en=1, cfg_addr/cfg_wdata/cfg_wstrb from buffers) -> WR_RESP with bresp=OKAY(00).
- Write, misaligned: no cfg_wr_en; -> WR_RESP with bresp=SLVERR(10).
- WR_RESP: bvalid=1 until bready; on handshake clear AW/W buffers, -> IDLE.
- Read, aligned: -> RD_ISSUE (cfg_rd_en=1, cfg_addr) -> RD_WAIT; counter cleared.
- RD_WAIT: cfg_rd_valid=1 -> capture cfg_rdata, rresp=OKAY, -> RD_RESP. Else counter+1; counter reaching RD_TIMEOUT -> rdata=0, rresp=SLVERR, -> RD_RESP.
- Read, misaligned: no cfg_rd_en; rdata=0, rresp=SLVERR, -> RD_RESP.
- RD_RESP: rvalid=1, rdata/rresp stable until rready; on handshake clear AR buffer, -> IDLE.
- cfg_rd_valid outside RD_WAIT ignored. cfg_wr_en and cfg_rd_en never high together.
- wstrb==0 on aligned write: still issued (cfg_wstrb=0), OKAY.

## Timing
- All outputs registered. Reset values: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=00; rdata=0; cfg_wr_en=cfg_rd_en=0; cfg_addr/cfg_wdata/cfg_wstrb=0; FSM=IDLE; last grant=read.
- Write: last of AW/W handshakes at edge of cycle 0, FSM IDLE -> cfg_wr_en in cycle 1, bvalid in cycle 2. Misaligned: bvalid in cycle 1. awready/wready return 1 the cycle after B handshake.
- Read: AR handshake at cycle 0 -> cfg_rd_en in cycle 1; cfg_rd_valid sampled from cycle 2; cfg_rd_valid in cycle k -> rvalid in cycle k+1. Timeout: no cfg_rd_valid in cycles 2..RD_TIMEOUT+1 -> rvalid in cycle RD_TIMEOUT+2.
- Response channels hold while ready low; no new cfg access while any response pending.
- Reset mid-transaction: all buffers/FSM cleared next edge; no cfg strobe in cycle after reset asserted; in-flight AXI transaction discarded.

## Test plan
- Aligned write awaddr=0x010, wdata=0xDEADBEEF, wstrb=0xF, AW and W same cycle -> cfg_wr_en one cycle with cfg_addr=0x010, data 0xDEADBEEF; bvalid 2 cycles later, bresp=00.
- W before AW by 3 cycles, bready held low 5 cycles -> single cfg_wr_en; bvalid held 5 cycles; wready stays 0 until B handshake.
- Aligned read araddr=0x020, cfg_rd_valid 4 cycles after cfg_rd_en with 0x12345678 -> rvalid next cycle, rdata=0x12345678, rresp=00.
- Read with cfg_rd_valid never asserted, RD_TIMEOUT=8 -> rvalid cycle 10 after AR handshake, rdata=0, rresp=10.
- Misaligned write 0x013 and read 0x022 -> no cfg strobes; bresp=10, rresp=10.
- Write and read pending in same IDLE cycle twice in a row -> write issued first, then read; next tie grants read first; reset asserted during RD_WAIT -> rvalid stays 0, arready=1 after reset.
